// File: rtl/top_job_arbiter.sv
// Round-robin job arbiter that sequences REQ_CNT requesters onto one serial accumulate engine.
// Optional WAIT-state timeout is compiled in with `define ARB_TIMEOUT_EN.
module top_job_arbiter #(
  parameter int REQ_CNT  = 4,
  parameter int RES_SIZE = 32,
  parameter int IN_SIZE  = 8,
  parameter int ACC_SIZE = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_CNT-1:0]          req,
  input  logic [REQ_CNT*ACC_SIZE-1:0] n_i,
  input  logic [REQ_CNT*IN_SIZE-1:0]  x_i,
  output logic [REQ_CNT-1:0]          gnt,
  output logic                        x_rd,
  output logic                        done,
  output logic [RES_SIZE-1:0]         res_o,
  output logic                        res_err,
  output logic                        res_ovf,
  output logic                        res_tmo,
  output logic                        busy,
  output logic                        eng_start,
  output logic [ACC_SIZE-1:0]         eng_n,
  output logic [IN_SIZE-1:0]          eng_x,
  input  logic                        eng_ready,
  input  logic                        eng_valid,
  input  logic                        eng_error,
  input  logic                        eng_overflow,
  input  logic [RES_SIZE-1:0]         eng_result
);
  localparam int PW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_FEED, S_WAIT, S_DONE} state_t;

  state_t                state_q;
  logic [PW-1:0]         ptr_q, win_q;
  logic [ACC_SIZE-1:0]   n_q, cnt_q;
  logic [REQ_CNT-1:0]    gnt_q;
  logic                  done_q, err_q, ovf_q;
  logic [RES_SIZE-1:0]   res_q;

  logic [REQ_CNT-1:0][ACC_SIZE-1:0] n_arr;
  logic [REQ_CNT-1:0][IN_SIZE-1:0]  x_arr;
  assign n_arr = n_i;
  assign x_arr = x_i;

  // Rotating priority scan: first set request at or after ptr, wrapping.
  logic [PW:0]   rr_idx;
  logic [PW-1:0] pick;
  logic          found;
  always_comb begin
    rr_idx = '0;
    pick   = '0;
    found  = 1'b0;
    for (int i = 0; i < REQ_CNT; i++) begin
      rr_idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (rr_idx >= (PW+1)'(REQ_CNT)) rr_idx = rr_idx - (PW+1)'(REQ_CNT);
      if (!found && req[rr_idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = rr_idx[PW-1:0];
      end
    end
  end

  assign eng_start = (state_q == S_GRANT) && eng_ready;
  assign x_rd      = (state_q == S_FEED);
  assign eng_x     = x_rd ? x_arr[win_q] : '0;
  assign eng_n     = (state_q == S_GRANT || state_q == S_FEED || state_q == S_WAIT) ? n_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign res_o     = res_q;
  assign res_err   = err_q;
  assign res_ovf   = ovf_q;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tcnt_q;
  logic          tmo_q;
  assign res_tmo = tmo_q;
`else
  assign res_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            win_q   <= pick;
            n_q     <= n_arr[pick];
            gnt_q   <= REQ_CNT'(1) << pick;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (eng_ready) begin
            cnt_q   <= '0;
            state_q <= S_FEED;
          end
        end
        S_FEED: begin
          cnt_q <= cnt_q + 1'b1;
          if (eng_error) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == n_q) begin
`ifdef ARB_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_valid) begin
            res_q   <= eng_result;
            err_q   <= eng_error;
            ovf_q   <= eng_overflow;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (eng_error) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          // TIMEOUT-th WAIT cycle with nothing from the engine ends the job.
          else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tcnt_q  <= tcnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          ptr_q   <= (win_q == PW'(REQ_CNT - 1)) ? '0 : win_q + 1'b1;
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_top_job_arbiter.sv
// Directed bench for top_job_arbiter; the test itself plays the engine.
module tb_top_job_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] n_i;
  logic [31:0] x_i;
  logic [3:0]  gnt;
  logic        x_rd, done, res_err, res_ovf, res_tmo, busy, eng_start;
  logic [31:0] res_o;
  logic [2:0]  eng_n;
  logic [7:0]  eng_x;
  logic        eng_ready, eng_valid, eng_error, eng_overflow;
  logic [31:0] eng_result;

  int checks = 0;
  int errors = 0;
  logic [7:0] smp [8];

  always #5 clk = ~clk;

  top_job_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .n_i(n_i), .x_i(x_i),
    .gnt(gnt), .x_rd(x_rd), .done(done), .res_o(res_o), .res_err(res_err),
    .res_ovf(res_ovf), .res_tmo(res_tmo), .busy(busy), .eng_start(eng_start),
    .eng_n(eng_n), .eng_x(eng_x), .eng_ready(eng_ready), .eng_valid(eng_valid),
    .eng_error(eng_error), .eng_overflow(eng_overflow), .eng_result(eng_result)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one job from IDLE for requester w; err_at<0 means the engine finishes normally.
  task automatic run_job(input int w, input int n, input int err_at,
                         input logic [31:0] result, input logic ovf);
    int k;
    n_i[w*3 +: 3] = n[2:0];
    x_i[w*8 +: 8] = smp[0];
    eng_ready = 1'b1; eng_valid = 1'b0; eng_error = 1'b0;
    step();
    chk("grant", {28'd0, gnt}, 32'd1 << w);
    chk("eng_start", {31'd0, eng_start}, 32'd1);
    chk("eng_n_grant", {29'd0, eng_n}, n);
    chk("busy_grant", {31'd0, busy}, 32'd1);
    step();
    k = 0;
    while (x_rd === 1'b1 && k < 16) begin
      chk("eng_x", {24'd0, eng_x}, {24'd0, smp[k % 8]});
      chk("eng_n_feed", {29'd0, eng_n}, n);
      if (k == err_at) eng_error = 1'b1;
      k++;
      step();
      eng_error = 1'b0;
      x_i[w*8 +: 8] = smp[k % 8];
      #1;
    end
    chk("x_rd_count", k, (err_at >= 0) ? err_at + 1 : n + 1);
    if (err_at < 0) begin
      chk("wait_no_done", {31'd0, done}, 32'd0);
      chk("wait_eng_x", {24'd0, eng_x}, 32'd0);
      chk("eng_n_wait", {29'd0, eng_n}, n);
      eng_valid = 1'b1; eng_result = result; eng_overflow = ovf;
      step();
      eng_valid = 1'b0; eng_overflow = 1'b0; eng_result = 32'd0;
      #1;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("grant_at_done", {28'd0, gnt}, 32'd1 << w);
    chk("res_o", res_o, (err_at >= 0) ? 32'd0 : result);
    chk("res_err", {31'd0, res_err}, (err_at >= 0) ? 32'd1 : 32'd0);
    chk("res_ovf", {31'd0, res_ovf}, (err_at >= 0) ? 32'd0 : {31'd0, ovf});
    chk("res_tmo", {31'd0, res_tmo}, 32'd0);
    step();
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("gnt_clear", {28'd0, gnt}, 32'd0);
    chk("res_hold", res_o, (err_at >= 0) ? 32'd0 : result);
  endtask

  initial begin
    int c;
    logic seen;
    smp[0] = 8'h06; smp[1] = 8'hC0; smp[2] = 8'h20; smp[3] = 8'h10;
    smp[4] = 8'h7F; smp[5] = 8'hC0; smp[6] = 8'h20; smp[7] = 8'h10;
    rst = 1'b0; req = '0; n_i = '0; x_i = '0;
    eng_ready = 1'b0; eng_valid = 1'b0; eng_error = 1'b0;
    eng_overflow = 1'b0; eng_result = '0;
    step(); step();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", res_o, 32'd0);
    rst = 1'b1;

    // Single job, N=7
    req = 4'b0001;
    run_job(0, 7, -1, 32'h1234_5678, 1'b0);
    // Engine error on the 3rd sample
    run_job(0, 4, 2, 32'd0, 1'b0);
    // Overflow
    req = 4'b0100;
    run_job(2, 2, -1, 32'hFFFF_FFFF, 1'b1);

    // Reset in the middle of FEED
    req = 4'b0010;
    n_i[3 +: 3] = 3'd5;
    x_i[8 +: 8] = smp[0];
    step();
    chk("mid_grant", {28'd0, gnt}, 32'd2);
    step(); step(); step(); step();
    chk("mid_feed", {31'd0, x_rd}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_xrd", {31'd0, x_rd}, 32'd0);
    chk("mid_rst_res", res_o, 32'd0);
    req = 4'b1010;
    seen = 1'b0;
    repeat (2) begin step(); if (done) seen = 1'b1; end
    chk("mid_rst_nodone", {31'd0, seen}, 32'd0);
    rst = 1'b1;
    run_job(1, 2, -1, 32'hA5A5_0001, 1'b0);

    // Fairness with all requesters held high
    req = 4'b0000;
    rst = 1'b0;
    step();
    rst = 1'b1;
    req = 4'b1111;
    for (int j = 0; j < 8; j++) run_job(j % 4, 1, -1, 32'h100 + j, 1'b0);
    req = 4'b0000;
    step();
    chk("idle_after_fair", {31'd0, busy}, 32'd0);

    // Engine never answers
    req = 4'b0001;
    n_i[2:0] = 3'd0;
    x_i[7:0] = smp[0];
    eng_ready = 1'b1;
    step(); step(); step();
    req = 4'b0000;
    chk("wait_busy", {31'd0, busy}, 32'd1);
`ifdef ARB_TIMEOUT_EN
    c = 0;
    while (done !== 1'b1 && c < 300) begin step(); c++; end
    chk("tmo_cycles", c, 64);
    chk("tmo_flag", {31'd0, res_tmo}, 32'd1);
    chk("tmo_err", {31'd0, res_err}, 32'd1);
    chk("tmo_res", res_o, 32'd0);
    step();
    chk("tmo_idle", {31'd0, busy}, 32'd0);
`else
    seen = 1'b0;
    c = 0;
    repeat (201) begin step(); c++; if (done) seen = 1'b1; end
    chk("hang_busy", {31'd0, busy}, 32'd1);
    chk("hang_nodone", {31'd0, seen}, 32'd0);
    chk("hang_tmo", {31'd0, res_tmo}, 32'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
